// File: rtl/mc_controller_v2_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS-subset controller.
//   state_t      : FSM state encoding (14 states, 4 bits)
//   OP_* / FN_*  : instruction opcode and funct field values
//   ALU_*        : 3-bit aluop codes
//   PC_*         : pcsource codes
//   SRCB_*       : alusrcb codes
//   M2R_*        : memtoreg codes
//   RD_*         : regdst codes
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_LINK_WB   = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // States that wait on the memory handshake and are covered by the watchdog.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mc_controller_v2_watchdog.sv
// mc_mem_watchdog: counts cycles a memory state spends waiting for mem_ready.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart count (state is changing)
//   inc        : a memory state is waiting this cycle
//   expire     : this waiting cycle is the last one allowed (MEM_TIMEOUT-th)
// MEM_TIMEOUT = 0 disables expiry; 2**TMO_W must exceed MEM_TIMEOUT.
module mc_mem_watchdog #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [TMO_W-1:0] LIMIT =
    (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] count;

  // Saturating counter so a disabled watchdog never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expire = (MEM_TIMEOUT != 0) && inc && (count == LIMIT);

endmodule

// File: rtl/mc_controller_v2.sv
// mc_controller_v2: multi-cycle MIPS-subset control FSM with a variable-latency
// memory handshake, memory watchdog, sticky error flags and a TRAP state.
//   clk, reset          : clock, synchronous active-high reset
//   op, funct, zero     : IR[31:26], IR[5:0], ALU zero flag
//   mem_ready           : memory completes the current access this cycle
//   pcen, pcwrite, memread, memwrite, irwrite, iord, regwrite, alusrca,
//   pcsource, alusrcb, aluop, memtoreg, regdst : datapath/memory controls
//   instr_done          : one-cycle pulse in the last cycle of an instruction
//   bus_err, illegal_op : sticky error flags, cleared only by reset
//   state_o             : current state for debug
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap on undecoded opcodes;
// otherwise they retire as NOPs and illegal_op stays 0.
module mc_controller_v2 import mc_ctrl_pkg::*; #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               pcwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               iord,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         pcsource,
  output logic [1:0]         alusrcb,
  output logic [2:0]         aluop,
  output logic [1:0]         memtoreg,
  output logic [1:0]         regdst,
  output logic               instr_done,
  output logic               bus_err,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_t state, nextstate;
  logic   branch_pcen;
  logic   bus_set;
  logic   wd_clear, wd_inc, wd_expire;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic   ill_set;
`endif

  mc_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  assign wd_inc   = is_mem_state(state) && !mem_ready;
  assign wd_clear = (nextstate != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      bus_err <= 1'b0;
    end else begin
      state <= nextstate;
      if (bus_set) bus_err <= 1'b1;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) illegal_op <= 1'b0;
    else if (ill_set) illegal_op <= 1'b1;
  end
`else
  assign illegal_op = 1'b0;
`endif

  // Memory states only advance on mem_ready; a timeout on the final waiting
  // cycle traps, but a completion in that same cycle takes priority.
  always_comb begin
    nextstate   = state;
    pcwrite     = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    iord        = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    pcsource    = PC_ALU;
    alusrcb     = SRCB_B;
    aluop       = ALU_ADD;
    memtoreg    = M2R_ALUOUT;
    regdst      = RD_RT;
    branch_pcen = 1'b0;
    bus_set     = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    ill_set     = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        aluop   = ALU_ADD;
        if (mem_ready) begin
          irwrite   = 1'b1;
          pcwrite   = 1'b1;
          nextstate = S_DECODE;
        end else if (wd_expire) begin
          nextstate = S_TRAP;
          bus_set   = 1'b1;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_SHIMM;
        aluop   = ALU_ADD;
        case (op)
          OP_RTYPE:
            nextstate = ((funct == FN_JR) || (funct == FN_JALR)) ? S_JUMP : S_R_EXEC;
          OP_LW, OP_SW:   nextstate = S_MEM_ADDR;
          OP_BEQ, OP_BNE: nextstate = S_BRANCH;
          OP_J, OP_JAL:   nextstate = S_JUMP;
          OP_ADDI, OP_ORI, OP_LUI, OP_ANDI, OP_XORI, OP_SLTI:
            nextstate = S_I_EXEC;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            ill_set   = 1'b1;
            nextstate = S_TRAP;
`else
            nextstate = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALU_ADD;
        if (op == OP_LW)      nextstate = S_MEM_READ;
        else if (op == OP_SW) nextstate = S_MEM_WRITE;
        else                  nextstate = S_FETCH;
      end
      S_MEM_READ: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          nextstate = S_MEM_WB;
        end else if (wd_expire) begin
          nextstate = S_TRAP;
          bus_set   = 1'b1;
        end
      end
      S_MEM_WB: begin
        regwrite  = 1'b1;
        memtoreg  = M2R_MDR;
        regdst    = RD_RT;
        nextstate = S_FETCH;
      end
      S_MEM_WRITE: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          nextstate = S_FETCH;
        end else if (wd_expire) begin
          nextstate = S_TRAP;
          bus_set   = 1'b1;
        end
      end
      S_R_EXEC: begin
        alusrca   = 1'b1;
        aluop     = ALU_FUNCT;
        nextstate = S_R_WB;
      end
      S_R_WB: begin
        regwrite  = 1'b1;
        regdst    = RD_RD;
        nextstate = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALU_SUB;
        pcsource    = PC_ALUOUT;
        branch_pcen = (op == OP_BNE) ? !zero : zero;
        nextstate   = S_FETCH;
      end
      S_JUMP: begin
        pcwrite   = 1'b1;
        pcsource  = (op == OP_RTYPE) ? PC_REGA : PC_JUMP;
        nextstate = ((op == OP_JAL) || ((op == OP_RTYPE) && (funct == FN_JALR)))
                    ? S_LINK_WB : S_FETCH;
      end
      S_LINK_WB: begin
        regwrite  = 1'b1;
        memtoreg  = M2R_PC;
        regdst    = (op == OP_JAL) ? RD_RA : RD_RD;
        nextstate = S_FETCH;
      end
      S_I_EXEC: begin
        alusrca = 1'b1;
        alusrcb = (op == OP_LUI) ? SRCB_SHIMM : SRCB_IMM;
        case (op)
          OP_ORI, OP_LUI: aluop = ALU_OR;
          OP_ANDI:        aluop = ALU_AND;
          OP_XORI:        aluop = ALU_XOR;
          OP_SLTI:        aluop = ALU_SLT;
          default:        aluop = ALU_ADD;
        endcase
        nextstate = S_I_WB;
      end
      S_I_WB: begin
        regwrite  = 1'b1;
        regdst    = RD_RT;
        nextstate = S_FETCH;
      end
      S_TRAP: begin
        nextstate = S_TRAP;
      end
      default: begin
        nextstate = S_FETCH;
      end
    endcase
  end

  assign pcen       = pcwrite | branch_pcen;
  assign instr_done = (nextstate == S_FETCH) && (state != S_FETCH) && (state != S_TRAP);
  assign state_o    = STATE_W'(state);

endmodule

// File: tb/tb_mc_controller_v2.sv
// tb_mc_controller_v2: scoreboard bench for mc_controller_v2.
// Each instruction is expanded by a reference model into a per-cycle list of
// (mem_ready to drive, expected control word). The driver applies the list
// and queues the expected words; a negedge monitor pops and compares.
// Honours CTRL_ILLEGAL_TRAP_EN for the undecoded-opcode case.
module tb_mc_controller_v2;

  localparam logic [5:0] T_R = 6'd0, T_J = 6'd2, T_JAL = 6'd3, T_BEQ = 6'd4, T_BNE = 6'd5;
  localparam logic [5:0] T_ADDI = 6'd8, T_SLTI = 6'd10, T_ANDI = 6'd12, T_ORI = 6'd13;
  localparam logic [5:0] T_XORI = 6'd14, T_LUI = 6'd15, T_LW = 6'd35, T_SW = 6'd43;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_JR = 5;
  localparam int C_JAL = 6, C_JALR = 7, C_I = 8, C_ILL = 9;

  typedef struct packed {
    logic       pcen, pcwrite, memread, memwrite, irwrite, iord, regwrite, alusrca;
    logic [1:0] pcsource, alusrcb;
    logic [2:0] aluop;
    logic [1:0] memtoreg, regdst;
    logic       instr_done, bus_err, illegal_op;
  } ctl_t;

  typedef struct {
    logic rdy;
    ctl_t c;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pcen, pcwrite, memread, memwrite, irwrite, iord, regwrite, alusrca;
  logic [1:0] pcsource, alusrcb, memtoreg, regdst;
  logic [2:0] aluop;
  logic       instr_done, bus_err, illegal_op;
  logic [3:0] state_o;

  step_t plan[$];
  ctl_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  m_bus = 1'b0, m_ill = 1'b0;
  string tag = "reset";

  mc_controller_v2 dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .pcwrite(pcwrite), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .iord(iord), .regwrite(regwrite), .alusrca(alusrca),
    .pcsource(pcsource), .alusrcb(alusrcb), .aluop(aluop), .memtoreg(memtoreg),
    .regdst(regdst), .instr_done(instr_done), .bus_err(bus_err),
    .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      T_R:             return (f == 6'd8) ? C_JR : (f == 6'd9) ? C_JALR : C_R;
      T_LW:            return C_LW;
      T_SW:            return C_SW;
      T_BEQ, T_BNE:    return C_BR;
      T_J:             return C_J;
      T_JAL:           return C_JAL;
      T_ADDI, T_ORI, T_LUI, T_ANDI, T_XORI, T_SLTI: return C_I;
      default:         return C_ILL;
    endcase
  endfunction

  function automatic ctl_t fetchWord(input logic rdy);
    ctl_t c = '0;
    c.memread = 1'b1;
    c.alusrcb = 2'b01;
    if (rdy) begin
      c.irwrite = 1'b1;
      c.pcwrite = 1'b1;
      c.pcen    = 1'b1;
    end
    return c;
  endfunction

  task automatic planPush(input logic rdy, input ctl_t cin);
    step_t s;
    s.c = cin;
    s.c.bus_err    = m_bus;
    s.c.illegal_op = m_ill;
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Reference model: the cycle-by-cycle control words an instruction produces.
  task automatic planInstr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw);
    ctl_t c;
    int   cls = classify(o, f);
    for (int i = 0; i < fw; i++) planPush(1'b0, fetchWord(1'b0));
    planPush(1'b1, fetchWord(1'b1));
    c = '0;
    c.alusrcb = 2'b11;
    if (cls == C_ILL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      planPush(rbit(), c);
      m_ill = 1'b1;
      for (int i = 0; i < 3; i++) planPush(rbit(), '0);
`else
      c.instr_done = 1'b1;
      planPush(rbit(), c);
`endif
      return;
    end
    planPush(rbit(), c);
    c = '0;
    case (cls)
      C_R: begin
        c.alusrca = 1'b1; c.aluop = 3'b010;
        planPush(rbit(), c);
        c = '0; c.regwrite = 1'b1; c.regdst = 2'b01; c.instr_done = 1'b1;
        planPush(rbit(), c);
      end
      C_LW, C_SW: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10;
        planPush(rbit(), c);
        c = '0; c.iord = 1'b1;
        c.memread = (cls == C_LW); c.memwrite = (cls == C_SW);
        for (int i = 0; i < mw; i++) planPush(1'b0, c);
        c.instr_done = (cls == C_SW);
        planPush(1'b1, c);
        if (cls == C_LW) begin
          c = '0; c.regwrite = 1'b1; c.memtoreg = 2'b01; c.instr_done = 1'b1;
          planPush(rbit(), c);
        end
      end
      C_BR: begin
        c.alusrca = 1'b1; c.aluop = 3'b001; c.pcsource = 2'b01; c.instr_done = 1'b1;
        c.pcen = (o == T_BEQ) ? z : !z;
        planPush(rbit(), c);
      end
      C_J, C_JR, C_JAL, C_JALR: begin
        c.pcwrite = 1'b1; c.pcen = 1'b1;
        c.pcsource = (cls == C_JR || cls == C_JALR) ? 2'b11 : 2'b10;
        c.instr_done = (cls == C_J || cls == C_JR);
        planPush(rbit(), c);
        if (cls == C_JAL || cls == C_JALR) begin
          c = '0; c.regwrite = 1'b1; c.memtoreg = 2'b10; c.instr_done = 1'b1;
          c.regdst = (cls == C_JAL) ? 2'b10 : 2'b01;
          planPush(rbit(), c);
        end
      end
      default: begin
        c.alusrca = 1'b1;
        c.alusrcb = (o == T_LUI) ? 2'b11 : 2'b10;
        case (o)
          T_ORI, T_LUI: c.aluop = 3'b011;
          T_ANDI:       c.aluop = 3'b100;
          T_XORI:       c.aluop = 3'b101;
          T_SLTI:       c.aluop = 3'b110;
          default:      c.aluop = 3'b000;
        endcase
        planPush(rbit(), c);
        c = '0; c.regwrite = 1'b1; c.instr_done = 1'b1;
        planPush(rbit(), c);
      end
    endcase
  endtask

  // Drive up to 'limit' planned cycles and queue their expected words.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input int limit);
    for (int i = 0; i < plan.size() && i < limit; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      op = o; funct = f; zero = z;
      mem_ready = plan[i].rdy;
      exp_q.push_back(plan[i].c);
    end
    plan.delete();
  endtask

  task automatic runInstr(input string t, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input int fw, input int mw);
    tag = t;
    planInstr(o, f, z, fw, mw);
    applyStimulus(o, f, z, 1000);
  endtask

  task automatic doReset(input int n);
    ctl_t c;
    logic r;
    tag = "reset";
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    m_bus = 1'b0;
    m_ill = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      r = rbit();
      mem_ready = r;
      c = fetchWord(r);
      exp_q.push_back(c);
    end
  endtask

  task automatic checkOutput(input ctl_t e, input ctl_t g);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("[TB] FAIL %s ctl @%0t: got %h, expected %h", tag, $time, g, e);
    end
  endtask

  always @(negedge clk) begin
    ctl_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '0;
      g.pcen = pcen; g.pcwrite = pcwrite; g.memread = memread; g.memwrite = memwrite;
      g.irwrite = irwrite; g.iord = iord; g.regwrite = regwrite; g.alusrca = alusrca;
      g.pcsource = pcsource; g.alusrcb = alusrcb; g.aluop = aluop;
      g.memtoreg = memtoreg; g.regdst = regdst; g.instr_done = instr_done;
      g.bus_err = bus_err; g.illegal_op = illegal_op;
      checkOutput(e, g);
    end
  end

  logic [5:0] ops [13] = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_JAL,
                           T_ADDI, T_ORI, T_LUI, T_ANDI, T_XORI, T_SLTI};

  initial begin
    logic [5:0] ro, rf;
    int         fw, mw;
    doReset(2);
    runInstr("lw_waits", T_LW, 6'd0, 1'b0, 3, 3);
    runInstr("bne_nz", T_BNE, 6'd0, 1'b0, 0, 0);
    runInstr("bne_z", T_BNE, 6'd0, 1'b1, 1, 0);
    runInstr("beq_z", T_BEQ, 6'd0, 1'b1, 0, 0);
    runInstr("jalr", T_R, 6'b001001, 1'b0, 0, 0);
    runInstr("jr", T_R, 6'b001000, 1'b0, 0, 0);
    runInstr("jal", T_JAL, 6'd0, 1'b0, 2, 0);
    runInstr("andi", T_ANDI, 6'd0, 1'b0, 0, 0);
    runInstr("xori", T_XORI, 6'd0, 1'b0, 0, 0);
    runInstr("slti", T_SLTI, 6'd0, 1'b0, 0, 0);
    runInstr("lui", T_LUI, 6'd0, 1'b0, 0, 0);
    runInstr("fetch_ready_at_15", T_SW, 6'd0, 1'b0, 14, 14);

    // Watchdog expiry in FETCH, then reset recovery.
    tag = "timeout";
    for (int i = 0; i < 15; i++) planPush(1'b0, fetchWord(1'b0));
    m_bus = 1'b1;
    for (int i = 0; i < 4; i++) planPush(rbit(), '0);
    applyStimulus(T_ADDI, 6'd0, 1'b0, 1000);
    doReset(2);

    // Expiry inside MEM_READ.
    tag = "timeout_memread";
    planInstr(T_LW, 6'd0, 1'b0, 0, 14);
    void'(plan.pop_back());
    void'(plan.pop_back());
    planPush(1'b0, plan[plan.size()-1].c);
    m_bus = 1'b1;
    for (int i = 0; i < 3; i++) planPush(rbit(), '0);
    applyStimulus(T_LW, 6'd0, 1'b0, 1000);
    doReset(1);

    // Reset while waiting in MEM_READ.
    tag = "reset_midwait";
    planInstr(T_LW, 6'd0, 1'b0, 1, 5);
    applyStimulus(T_LW, 6'd0, 1'b0, 7);
    doReset(1);

    runInstr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0);
    doReset(1);

    for (int n = 0; n < 60; n++) begin
      ro = ops[$urandom_range(0, 12)];
      rf = 6'($urandom_range(0, 63));
      if (ro == T_R && $urandom_range(0, 3) == 0) rf = 6'($urandom_range(8, 9));
`ifndef CTRL_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 9) == 0) ro = 6'($urandom_range(0, 63));
`endif
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 2);
      runInstr("random", ro, rf, rbit(), fw, mw);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
